// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder, 1 info bit in -> 1 coded pair out,
// single-entry registered output; tail flush built only with ENC_TAIL_EN.
// Ports: clk, rst_n (async low), in_bit/in_valid/in_ready (info side),
//   enc_pair/enc_valid/enc_ready (symbol side), enc_tail, enc_last (framing).
module conv_encoder_k3 #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] enc_pair,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       enc_tail,
  output logic       enc_last
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    DATA  = 2'd0,
    TAIL1 = 2'd1,
    TAIL2 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pair_q, pair_d;
  logic          valid_q, valid_d;
  logic          tail_q, tail_d;
  logic          last_q, last_d;

  logic          slot_free;
  logic          load_data;
  logic          load_tail;
  logic          ld_bit;
  logic [2:0]    r;
  logic          cnt_end;

  always_comb begin
    slot_free = !valid_q || enc_ready;
    in_ready  = rst_n && slot_free && (state_q == DATA);
    load_data = in_valid && in_ready;
`ifdef ENC_TAIL_EN
    load_tail = slot_free && (state_q != DATA);
`else
    load_tail = 1'b0;
`endif
    // flush symbols shift zeros in
    ld_bit  = load_data ? in_bit : 1'b0;
    r       = {ld_bit, sr_q};
    cnt_end = (cnt_q == LAST_CNT);

    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    valid_d = valid_q;
    tail_d  = tail_q;
    last_d  = last_q;

    if (load_data || load_tail) begin
      sr_d    = {ld_bit, sr_q[1]};
      pair_d  = {^(G1 & r), ^(G0 & r)};
      valid_d = 1'b1;
      tail_d  = load_tail;
      last_d  = 1'b0;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    if (load_data) begin
`ifdef ENC_TAIL_EN
      cnt_d = cnt_q + CW'(1);
      if (cnt_end) begin
        state_d = TAIL1;
      end
`else
      if (cnt_end) begin
        cnt_d  = '0;
        last_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
`endif
    end

`ifdef ENC_TAIL_EN
    if (load_tail) begin
      if (state_q == TAIL1) begin
        state_d = TAIL2;
      end else begin
        state_d = DATA;
        cnt_d   = '0;
        last_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DATA;
      sr_q    <= 2'b00;
      cnt_q   <= '0;
      pair_q  <= 2'b00;
      valid_q <= 1'b0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
    end
  end

  assign enc_pair  = pair_q;
  assign enc_valid = valid_q;
  assign enc_tail  = tail_q;
  assign enc_last  = last_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: directed vector tables, backpressure,
// mid-frame reset and randomized traffic against a bit-history model.
module tb_conv_encoder_k3;

  localparam int FL = 4;
  localparam logic [2:0] TG0 = 3'b111;
  localparam logic [2:0] TG1 = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] enc_pair;
  logic       enc_valid;
  logic       enc_ready = 1'b0;
  logic       enc_tail;
  logic       enc_last;

  always #5 clk = ~clk;

  conv_encoder_k3 #(.FRAME_LEN(FL), .G0(TG0), .G1(TG1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .enc_pair(enc_pair),
    .enc_valid(enc_valid),
    .enc_ready(enc_ready),
    .enc_tail(enc_tail),
    .enc_last(enc_last)
  );

  typedef struct packed {
    logic [1:0] pair;
    logic       tail;
    logic       last;
  } sym_t;

  typedef struct {
    logic b;
    sym_t s;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;
  sym_t obs_q[$];
  sym_t exp_q[$];
  logic acc_q[$];
  sym_t prev_sym;
  logic prev_hold = 1'b0;
  vec_t tv[6];
  int   n_vec;
  logic [15:0] tv_bits;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Output monitor: records transfers and checks stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        chk("hold_valid", {7'd0, enc_valid}, 8'd1);
        chk("hold_sym", {4'd0, enc_pair, enc_tail, enc_last},
            {4'd0, prev_sym});
      end
      if (enc_valid && !enc_ready)
        chk("stall_in_ready", {7'd0, in_ready}, 8'd0);
      prev_hold = enc_valid && !enc_ready;
      prev_sym  = {enc_pair, enc_tail, enc_last};
      if (enc_valid && enc_ready)
        obs_q.push_back({enc_pair, enc_tail, enc_last});
      if (in_valid && in_ready)
        acc_q.push_back(in_bit);
      if (in_valid && !in_ready)
        stall_cnt++;
`ifdef ENC_TAIL_EN
      if (enc_valid && enc_last)
        chk("sr_at_last", {6'd0, dut.sr_q}, 8'd0);
`endif
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Reference: each symbol is the generator-weighted parity of the
  // current bit and the two bits before it in the transmitted stream.
  function automatic sym_t mk(input int b, input int p1, input int p2,
                              input logic t, input logic l);
    int   s0, s1;
    sym_t s;
    s0 = (TG0[2] ? b : 0) + (TG0[1] ? p1 : 0) + (TG0[0] ? p2 : 0);
    s1 = (TG1[2] ? b : 0) + (TG1[1] ? p1 : 0) + (TG1[0] ? p2 : 0);
    s.pair = {logic'(s1 % 2), logic'(s0 % 2)};
    s.tail = t;
    s.last = l;
    return s;
  endfunction

  task automatic build_model();
    int p1, p2, b;
    p1 = 0;
    p2 = 0;
    exp_q.delete();
    for (int i = 0; i < acc_q.size(); i++) begin
      b = int'(acc_q[i]);
`ifdef ENC_TAIL_EN
      exp_q.push_back(mk(b, p1, p2, 1'b0, 1'b0));
      p2 = p1;
      p1 = b;
      if (i % FL == FL - 1) begin
        for (int k = 0; k < 2; k++) begin
          exp_q.push_back(mk(0, p1, p2, 1'b1, logic'(k == 1)));
          p2 = p1;
          p1 = 0;
        end
      end
`else
      exp_q.push_back(mk(b, p1, p2, 1'b0, logic'(i % FL == FL - 1)));
      p2 = p1;
      p1 = b;
`endif
    end
  endtask

  task automatic cmp_model(input string nm);
    int n;
    build_model();
    chk({nm, "_len"}, 8'(obs_q.size()), 8'(exp_q.size()));
    n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk(nm, {4'd0, obs_q[i]}, {4'd0, exp_q[i]});
  endtask

  task automatic cmp_table(input string nm, input int base);
    chk({nm, "_len"}, 8'(obs_q.size()), 8'(base + n_vec));
    for (int i = 0; i < n_vec; i++)
      if (base + i < obs_q.size())
        chk(nm, {4'd0, obs_q[base + i]}, {4'd0, tv[i].s});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    enc_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", {7'd0, enc_valid}, 8'd0);
    chk("rst_pair", {6'd0, enc_pair}, 8'd0);
    chk("rst_tail", {7'd0, enc_tail}, 8'd0);
    chk("rst_last", {7'd0, enc_last}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    obs_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present bits LSB first, holding each until accepted
  task automatic send(input int n, input logic [15:0] v);
    int w;
    for (int i = 0; i < n; i++) begin
      in_bit = v[i];
      in_valid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!in_ready && w < 50);
      if (!in_ready)
        chk("send_timeout", 8'd0, 8'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    enc_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   sent, cyc;
    logic took;
`ifdef ENC_TAIL_EN
    n_vec = 6;
    tv_bits = 16'h000D;
    tv[0] = '{1'b1, '{2'b11, 1'b0, 1'b0}};
    tv[1] = '{1'b0, '{2'b01, 1'b0, 1'b0}};
    tv[2] = '{1'b1, '{2'b00, 1'b0, 1'b0}};
    tv[3] = '{1'b1, '{2'b10, 1'b0, 1'b0}};
    tv[4] = '{1'b0, '{2'b10, 1'b1, 1'b0}};
    tv[5] = '{1'b0, '{2'b11, 1'b1, 1'b1}};
`else
    n_vec = 5;
    tv_bits = 16'h000D;
    tv[0] = '{1'b1, '{2'b11, 1'b0, 1'b0}};
    tv[1] = '{1'b0, '{2'b01, 1'b0, 1'b0}};
    tv[2] = '{1'b1, '{2'b00, 1'b0, 1'b0}};
    tv[3] = '{1'b1, '{2'b10, 1'b0, 1'b1}};
    tv[4] = '{1'b0, '{2'b10, 1'b0, 1'b0}};
    tv[5] = '{1'b0, '{2'b00, 1'b0, 1'b0}};
`endif

    // Directed frame with latency check on the first bit
    do_reset();
    enc_ready = 1'b1;
    in_bit = tv[0].b;
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_pre_valid", {7'd0, enc_valid}, 8'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", {7'd0, enc_valid}, 8'd1);
    chk("lat_pair", {6'd0, enc_pair}, {6'd0, tv[0].s.pair});
    @(posedge clk);
    #1;
    send(`ifdef ENC_TAIL_EN 3 `else 4 `endif, tv_bits >> 1);
    drain(8);
    cmp_table("t1_vec", 0);

    // Back-to-back frames with in_valid held high
    do_reset();
    enc_ready = 1'b1;
    stall_cnt = 0;
    send(2 * FL, 16'h00DD);
`ifdef ENC_TAIL_EN
    chk("t2_stalls", 8'(stall_cnt), 8'd2);
`else
    chk("t2_stalls", 8'(stall_cnt), 8'd0);
`endif
    drain(8);
    cmp_model("t2_model");
`ifdef ENC_TAIL_EN
    for (int i = 0; i < n_vec; i++)
      if (n_vec + i < obs_q.size())
        chk("t2_frame2", {4'd0, obs_q[n_vec + i]}, {4'd0, tv[i].s});
`endif

    // Backpressure with a pending symbol
    do_reset();
    enc_ready = 1'b0;
    in_bit = tv[0].b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_bit = tv[1].b;
    repeat (5) begin
      @(negedge clk);
      chk("t3_valid", {7'd0, enc_valid}, 8'd1);
      chk("t3_pair", {6'd0, enc_pair}, {6'd0, tv[0].s.pair});
      chk("t3_in_ready", {7'd0, in_ready}, 8'd0);
    end
    @(posedge clk);
    #1;
    enc_ready = 1'b1;
    send(`ifdef ENC_TAIL_EN 3 `else 4 `endif, tv_bits >> 1);
    drain(8);
    cmp_table("t3_vec", 0);

    // Reset mid-frame
    do_reset();
    enc_ready = 1'b1;
    send(2, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("t4_valid", {7'd0, enc_valid}, 8'd0);
    chk("t4_pair", {6'd0, enc_pair}, 8'd0);
    chk("t4_last", {7'd0, enc_last}, 8'd0);
    chk("t4_in_ready", {7'd0, in_ready}, 8'd0);
    do_reset();
    enc_ready = 1'b1;
    send(n_vec `ifdef ENC_TAIL_EN - 2 `endif, tv_bits);
    drain(8);
    cmp_table("t4_vec", 0);

    // Randomized traffic, 200 frames
    do_reset();
    sent = 0;
    cyc = 0;
    took = 1'b0;
    while (sent < 200 * FL && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (took) begin
        in_valid = 1'b0;
        took = 1'b0;
      end
      if (!in_valid && sent < 200 * FL) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bit = logic'($urandom_range(0, 1));
      end
      enc_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        took = 1'b1;
        sent++;
      end
    end
    if (sent < 200 * FL)
      chk("t6_timeout", 8'd0, 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(10);
    cmp_model("t6_model");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
